instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Memory-side responder for the CPU instruction-fetch bus. Takes fetch addresses from the fetch stage and returns 32-bit instruction words after a fixed pipelined latency.
- Holds a word-addressed instruction store with a write port for program loading by a loader or bench.
- Supports a flush input, driven by the branch-taken signal, that kills in-flight fetches from the wrong path.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the store (power of 2, 16..65536).
- BASE_ADDR, 32'h0, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to resp_valid (legal 1..4).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_address  input  32  byte address of the instruction.
- flush  input  1  discard all in-flight requests.
- resp_valid  output  1  resp_data and resp_error are valid this cycle.
- resp_data  output  32  instruction word.
- resp_error  output  1  the request was misaligned or out of range.
- busy  output  1  at least one request is in flight.
- wr_enable  input  1  write a word into the store.
- wr_address  input  32  byte address of the write.
- wr_data  input  32  write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline stage valid bits clear.
  - resp_valid=0, resp_data=32'h0, resp_error=0, busy=0, req_ready=0.
  - Store contents are not reset.
  - After reset deasserts, req_ready=1 from the first clock edge onward.
- Acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready is 1 whenever reset is deasserted. There is no backpressure, so one request can be accepted per cycle.
- Address check at acceptance: offset = req_address - BASE_ADDR.
  - The request is legal iff offset[1:0]==0, req_address >= BASE_ADDR, and offset[31:2] < DEPTH_WORDS.
  - Illegal request: response carries resp_data=32'h0 and resp_error=1.
- Read timing:
  - The store is read in the acceptance cycle, and the word plus error flag are captured into stage 1.
  - The pipeline is LATENCY stages deep, each stage holding {valid, data, error}. The data shifts one stage per cycle.
  - resp_valid/resp_data/resp_error are driven from the last stage register.
  - A request accepted at edge t produces resp_valid=1 for exactly one cycle, after edge t+LATENCY-1 (i.e. visible in cycle t+LATENCY).
- Ordering: responses come back in acceptance order, with no gaps added. Back-to-back requests give back-to-back responses.
- Idle response outputs: when resp_valid=0, resp_data and resp_error hold their last values.
- Writes:
  - A write is committed at the edge where wr_enable=1, subject to the same legality check on wr_address.
  - Illegal writes are silently dropped.
- Simultaneous write and read to the same word in the same cycle is write-first: the read returns wr_data.
- Flush:
  - flush=1 at an edge clears the valid bits of all stages holding earlier requests, so no response is issued for them.
  - A request accepted on the same edge as flush is kept (it is the new-path fetch).
  - In the cycle after a flush, resp_valid=0 unless LATENCY=1 and a request was accepted with the flush.
- busy = OR of all stage valid bits.
- Reset asserted mid-operation drops all in-flight requests immediately, with no responses.

Test Plan:
- Load and read: BASE_ADDR=0, LATENCY=2. Write 0x00000013 to address 0x10. Request 0x10 at cycle 5 -> resp_valid=1 in cycle 7, resp_data=0x00000013, resp_error=0.
- Streaming: write words 0xA0..0xA3 to 0x0..0xC. Request 0x0, 0x4, 0x8, 0xC on consecutive cycles -> four consecutive resp_valid cycles returning 0xA0, 0xA1, 0xA2, 0xA3 in order. busy falls on the cycle after the last response.
- Errors, with DEPTH_WORDS=1024:
  - Request 0x6 -> resp_error=1, resp_data=0.
  - Request 0x1000 -> resp_error=1.
  - Write to 0x1000, then read 0xFFC -> the 0xFFC contents are unchanged.
- Flush: LATENCY=3. Request 0x20 and 0x24 on consecutive cycles, then on the next cycle request 0x40 with flush=1 -> only the 0x40 word is returned, three cycles after its acceptance. No response for 0x20 or 0x24.
- Write-first: with 0x8 holding 0x11, issue wr_enable to 0x8 with data 0x22 and a read request of 0x8 in the same cycle -> response data 0x22.
- Reset mid-flight: accept a request, then drive reset=0 for one cycle before its response is due -> resp_valid stays 0 and busy=0 immediately. After release, a new request is served with normal latency.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: word-addressed store with a write port
// for program loading, and a fixed-latency read pipeline that a flush can kill.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        busy,
  input  logic        wr_enable,
  input  logic [31:0] wr_address,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic               r_ready;
  logic [LATENCY-1:0] r_vld;
  logic [31:0]        r_data [LATENCY];
  logic [LATENCY-1:0] r_err;

  // 33-bit differences: bit 32 is the borrow, set when the address is below BASE_ADDR.
  logic [32:0]   w_rd_diff;
  logic [32:0]   w_wr_diff;
  logic          w_rd_legal;
  logic          w_wr_legal;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_accept;
  logic [31:0]   w_s0_data;

  // Address decode and legality check for both the read and the write port.
  always_comb begin
    w_rd_diff  = {1'b0, req_address} - {1'b0, BASE_ADDR};
    w_wr_diff  = {1'b0, wr_address} - {1'b0, BASE_ADDR};
    w_rd_legal = !w_rd_diff[32] && (w_rd_diff[1:0] == 2'b00) &&
                 ({2'b00, w_rd_diff[31:2]} < DEPTH_WORDS);
    w_wr_legal = !w_wr_diff[32] && (w_wr_diff[1:0] == 2'b00) &&
                 ({2'b00, w_wr_diff[31:2]} < DEPTH_WORDS);
    w_rd_idx   = w_rd_diff[AW+1:2];
    w_wr_idx   = w_wr_diff[AW+1:2];
  end

  // Stage-0 capture value: write-first bypass on a same-word write, zero on an illegal read.
  always_comb begin
    w_accept  = req_valid && r_ready;
    w_s0_data = 32'h0;
    if (w_rd_legal) begin
      if (wr_enable && w_wr_legal && (w_wr_idx == w_rd_idx)) begin
        w_s0_data = wr_data;
      end else begin
        w_s0_data = r_mem[w_rd_idx];
      end
    end
  end

  // Store write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_enable && w_wr_legal) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // Read pipeline: data only moves with a valid entry so the outputs hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_vld   <= '0;
      r_err   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= 32'h0;
      end
    end else begin
      r_ready  <= 1'b1;
      r_vld[0] <= w_accept;
      if (w_accept) begin
        r_data[0] <= w_s0_data;
        r_err[0]  <= !w_rd_legal;
      end
      // Flush kills everything already in flight; stage 0 keeps the new-path fetch.
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1] && !flush;
        if (r_vld[i-1] && !flush) begin
          r_data[i] <= r_data[i-1];
          r_err[i]  <= r_err[i-1];
        end
      end
    end
  end

  // Outputs come straight from the last stage.
  always_comb begin
    req_ready  = r_ready;
    resp_valid = r_vld[LATENCY-1];
    resp_data  = r_data[LATENCY-1];
    resp_error = r_err[LATENCY-1];
    busy       = |r_vld;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: a LATENCY=2 and a LATENCY=3 instance
// share one set of stimulus; expected values are hand-computed.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_address;
  logic        flush;
  logic        wr_enable;
  logic [31:0] wr_address;
  logic [31:0] wr_data;

  logic        req_ready, resp_valid, resp_error, busy;
  logic [31:0] resp_data;
  logic        req_ready3, resp_valid3, resp_error3, busy3;
  logic [31:0] resp_data3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .flush(flush), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_error(resp_error), .busy(busy),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data)
  );

  instr_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_address(req_address), .flush(flush), .resp_valid(resp_valid3),
    .resp_data(resp_data3), .resp_error(resp_error3), .busy(busy3),
    .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    wr_enable = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    wr_enable  = 1'b1;
    wr_address = addr;
    wr_data    = data;
    tick();
    wr_enable  = 1'b0;
  endtask

  // Single request on the LATENCY=2 instance, checked one cycle after acceptance.
  task automatic read_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
    req_valid   = 1'b1;
    req_address = addr;
    tick();
    req_valid = 1'b0;
    chk({tag, "_early"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, 32'(resp_error), 32'(exp_err));
  endtask

  initial begin
    reset       = 1'b0;
    req_address = 32'h0;
    wr_address  = 32'h0;
    wr_data     = 32'h0;
    idle();

    // Reset state
    #3;
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_err", 32'(resp_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    #4;
    reset = 1'b1;
    tick();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Load and read
    write_word(32'h10, 32'h0000_0013);
    req_valid   = 1'b1;
    req_address = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("ld_early_vld", 32'(resp_valid), 32'd0);
    chk("ld_busy", 32'(busy), 32'd1);
    tick();
    chk("ld_vld", 32'(resp_valid), 32'd1);
    chk("ld_data", resp_data, 32'h0000_0013);
    chk("ld_err", 32'(resp_error), 32'd0);
    tick();
    chk("ld_vld_drop", 32'(resp_valid), 32'd0);
    chk("ld_data_hold", resp_data, 32'h0000_0013);
    chk("ld_busy_drop", 32'(busy), 32'd0);

    // Streaming: four back-to-back requests
    for (int i = 0; i < 4; i++) write_word(32'(4 * i), 32'hA0 + 32'(i));
    for (int j = 0; j < 7; j++) begin
      req_valid   = (j < 4);
      req_address = 32'(4 * j);
      tick();
      chk("st_vld", 32'(resp_valid), 32'(j >= 1 && j <= 4));
      if (j >= 1 && j <= 4) chk("st_data", resp_data, 32'hA0 + 32'(j - 1));
      chk("st_busy", 32'(busy), 32'(j <= 4));
    end

    // Errors
    read_check("mis", 32'h6, 32'h0, 1'b1);
    read_check("oor", 32'h1000, 32'h0, 1'b1);
    write_word(32'hFFC, 32'h5555_0001);
    write_word(32'h1000, 32'hDEAD_BEEF);
    read_check("top", 32'hFFC, 32'h5555_0001, 1'b0);

    // Flush: words for 0x20, 0x24, 0x40
    write_word(32'h20, 32'hB0);
    write_word(32'h24, 32'hB1);
    write_word(32'h40, 32'hB2);
    tick();
    req_valid   = 1'b1;
    req_address = 32'h20;
    tick();
    req_address = 32'h24;
    tick();
    chk("fl2_old_vld", 32'(resp_valid), 32'd1);
    chk("fl2_old_data", resp_data, 32'hB0);
    chk("fl3_pre_vld", 32'(resp_valid3), 32'd0);
    req_address = 32'h40;
    flush       = 1'b1;
    tick();
    idle();
    chk("fl3_vld_a", 32'(resp_valid3), 32'd0);
    chk("fl3_busy", 32'(busy3), 32'd1);
    chk("fl2_vld_a", 32'(resp_valid), 32'd0);
    tick();
    chk("fl3_vld_b", 32'(resp_valid3), 32'd0);
    chk("fl2_vld_b", 32'(resp_valid), 32'd1);
    chk("fl2_data_b", resp_data, 32'hB2);
    tick();
    chk("fl3_vld_c", 32'(resp_valid3), 32'd1);
    chk("fl3_data_c", resp_data3, 32'hB2);
    chk("fl3_err_c", 32'(resp_error3), 32'd0);
    tick();
    chk("fl3_vld_d", 32'(resp_valid3), 32'd0);
    chk("fl3_busy_d", 32'(busy3), 32'd0);

    // Write-first on the same word
    write_word(32'h8, 32'h11);
    read_check("pre_wf", 32'h8, 32'h11, 1'b0);
    wr_enable   = 1'b1;
    wr_address  = 32'h8;
    wr_data     = 32'h22;
    req_valid   = 1'b1;
    req_address = 32'h8;
    tick();
    idle();
    tick();
    chk("wf_vld", 32'(resp_valid), 32'd1);
    chk("wf_data", resp_data, 32'h22);
    read_check("wf_after", 32'h8, 32'h22, 1'b0);

    // Reset mid-flight
    req_valid   = 1'b1;
    req_address = 32'h10;
    tick();
    idle();
    chk("mr_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_vld", 32'(resp_valid), 32'd0);
    chk("mr_data", resp_data, 32'h0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mr_vld_due", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk("mr_ready_back", 32'(req_ready), 32'd1);
    chk("mr_vld_after", 32'(resp_valid), 32'd0);
    read_check("mr_new", 32'h10, 32'h0000_0013, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
